// File: rtl/slice_scheduler_if.sv
// Handshake bundle between a wide word producer, the slice scheduler and a
// narrow slice consumer. The scheduler uses the slave modport.
interface slice_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
);
    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = $clog2(N);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [SLICE-1:0] out_data;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_last, out_valid
    );
endinterface

// File: rtl/slice_scheduler.sv
// Emits the slices of a wide word one per handshake in a runtime-programmable
// slot order; the order is latched per word so a word never changes mid-flight.
module slice_scheduler #(
    parameter  int WIDTH = 16,
    parameter  int SLICE = 4,
    localparam int N     = WIDTH / SLICE,
    localparam int IDXW  = $clog2(N)
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [N*IDXW-1:0]   cfg_order_i,
    input  logic                cfg_load_i,
    slice_scheduler_if.slave    bus,
    output logic                busy_o
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [IDXW-1:0] LAST_SLOT = IDXW'(N - 1);

    function automatic logic [N*IDXW-1:0] identity_order();
        logic [N*IDXW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k*IDXW +: IDXW] = IDXW'(k);
        end
        return r;
    endfunction

    state_t              state_q;
    logic [WIDTH-1:0]    word_q;
    logic [IDXW-1:0]     slot_q;
    logic                out_valid_q;
    logic [N*IDXW-1:0]   active_q;
    logic [N*IDXW-1:0]   pending_q;
    logic [N*IDXW-1:0]   pending_d;

    logic                in_ready_s;
    logic                word_acc_s;
    logic                slice_acc_s;
    logic [IDXW-1:0]     out_idx_s;
    logic [IDXW-1:0]     order_arr_s [N];
    logic [SLICE-1:0]    slice_arr_s [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign order_arr_s[k] = active_q[k*IDXW +: IDXW];
        assign slice_arr_s[k] = word_q[k*SLICE +: SLICE];
    end

    // A word may enter while idle, or in the same cycle the last slot leaves.
    assign in_ready_s  = !out_valid_q || (bus.out_ready && (slot_q == LAST_SLOT));
    assign word_acc_s  = bus.in_valid && in_ready_s;
    assign slice_acc_s = out_valid_q && bus.out_ready;
    // Same-edge cfg_load bypasses the pending register for the accepted word.
    assign pending_d   = cfg_load_i ? cfg_order_i : pending_q;

    assign out_idx_s     = order_arr_s[slot_q];
    assign bus.in_ready  = in_ready_s;
    assign bus.out_idx   = out_idx_s;
    assign bus.out_data  = slice_arr_s[out_idx_s];
    assign bus.out_last  = out_valid_q && (slot_q == LAST_SLOT);
    assign bus.out_valid = out_valid_q;
    assign busy_o        = out_valid_q;

    // Scheduler FSM with word, slot, and order registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            active_q    <= identity_order();
            pending_q   <= identity_order();
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (word_acc_s) begin
                        word_q      <= bus.in_data;
                        slot_q      <= '0;
                        active_q    <= pending_d;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (slice_acc_s) begin
                        if (slot_q != LAST_SLOT) begin
                            slot_q <= slot_q + IDXW'(1);
                        end else if (word_acc_s) begin
                            word_q   <= bus.in_data;
                            slot_q   <= '0;
                            active_q <= pending_d;
                        end else begin
                            slot_q      <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    slot_q      <= '0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slice_scheduler.sv
// Scoreboard bench for slice_scheduler: a reference model expands every
// accepted word into its expected slices; a monitor compares each presented slice.
module tb_slice_scheduler;
    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = 4;
    localparam int IDXW  = 2;

    typedef struct {
        logic [3:0] d;
        logic [1:0] i;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] cfg_order;
    logic       cfg_load;
    logic       busy;
    logic       rmode = 1'b0;
    logic [7:0] pending_m = 8'hE4;
    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    slice_scheduler_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

    slice_scheduler #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk         (clk),
        .arst        (arst),
        .cfg_order_i (cfg_order),
        .cfg_load_i  (cfg_load),
        .bus         (bus),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on each word accept, list the slices the word must produce.
    initial begin : model
        logic [7:0] ord;
        int idx;
        forever begin
            @(negedge clk);
            #3;
            if (!arst) begin
                if (bus.in_valid && bus.in_ready) begin
                    ord = cfg_load ? cfg_order : pending_m;
                    for (int k = 0; k < N; k++) begin
                        exp_t e;
                        idx  = int'(ord[k*IDXW +: IDXW]);
                        e.d  = bus.in_data[idx*SLICE +: SLICE];
                        e.i  = ord[k*IDXW +: IDXW];
                        e.l  = (k == N - 1);
                        sb.push_back(e);
                    end
                end
                if (cfg_load) pending_m = cfg_order;
            end
        end
    end

    // Monitor: compare every cycle's outputs against the head of the scoreboard.
    initial begin : monitor
        logic ev;
        logic er;
        forever begin
            @(negedge clk);
            #2;
            if (!arst) begin
                ev = (sb.size() != 0);
                er = ev ? (bus.out_ready && sb[0].l) : 1'b1;
                chk("out_valid", 16'(bus.out_valid), 16'(ev));
                chk("busy", 16'(busy), 16'(ev));
                chk("in_ready", 16'(bus.in_ready), 16'(er));
                if (ev) begin
                    chk("out_data", 16'(bus.out_data), 16'(sb[0].d));
                    chk("out_idx", 16'(bus.out_idx), 16'(sb[0].i));
                    chk("out_last", 16'(bus.out_last), 16'(sb[0].l));
                    if (bus.out_ready) void'(sb.pop_front());
                end else begin
                    chk("out_last_idle", 16'(bus.out_last), 16'd0);
                end
            end
        end
    end

    task automatic drive_ready();
        bus.out_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
        cfg_load      = 1'b0;
    endtask

    // Present a word and hold it until accepted; returns on the negedge after acceptance.
    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            drive_ready();
            #1;
            n++;
        end
        chk("send_timeout", 16'(n >= 200), 16'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drive_ready();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        #1;
        while (bus.out_valid && n < 500) begin
            @(negedge clk);
            drive_ready();
            #1;
            n++;
        end
        chk("idle_timeout", 16'(n >= 500), 16'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
        chk({tag, "_out_valid"}, 16'(bus.out_valid), 16'd0);
        chk({tag, "_out_data"}, 16'(bus.out_data), 16'd0);
        chk({tag, "_out_idx"}, 16'(bus.out_idx), 16'd0);
        chk({tag, "_out_last"}, 16'(bus.out_last), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        arst          = 1'b1;
        bus.in_data   = 16'($urandom);
        bus.in_valid  = 1'($urandom);
        bus.out_ready = 1'($urandom);
        cfg_order     = 8'($urandom);
        cfg_load      = 1'($urandom);
        #1;
        reset_checks("reset");

        // Identity order after reset, 0xBEEF -> F,E,E,B.
        @(negedge clk);
        arst = 1'b0;
        bus.in_valid = 1'b0;
        drive_ready();
        send(16'hBEEF);
        wait_idle();

        // Custom order {1,0,3,2} applied before the word.
        @(negedge clk);
        cfg_order = 8'hB1;
        cfg_load  = 1'b1;
        @(negedge clk);
        drive_ready();
        send(16'h1234);
        wait_idle();

        // Identity reloaded on the same edge as the accept, then back-to-back words.
        @(negedge clk);
        cfg_order = 8'hE4;
        cfg_load  = 1'b1;
        send(16'hA5C3);
        send(16'h0F0F);
        wait_idle();

        // Backpressure on slot 1 with a mid-word reorder to reversed.
        @(negedge clk);
        send(16'h1234);
        @(negedge clk);
        bus.out_ready = 1'b0;
        cfg_order     = 8'h1B;
        cfg_load      = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive_ready();
        send(16'hCAFE);
        wait_idle();

        // Reset while slot 2 is on the output.
        @(negedge clk);
        send(16'h9876);
        @(negedge clk);
        drive_ready();
        @(negedge clk);
        drive_ready();
        arst = 1'b1;
        sb.delete();
        pending_m = 8'hE4;
        #1;
        reset_checks("midreset");
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        drive_ready();
        send(16'h4321);
        wait_idle();

        // Randomized traffic: random data, orders (duplicates allowed), stalls and gaps.
        @(negedge clk);
        for (int it = 0; it < 80; it++) begin
            rmode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                cfg_order = 8'($urandom);
                cfg_load  = 1'b1;
            end
            send(16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 6)) begin
                    @(negedge clk);
                    drive_ready();
                end
            end
        end
        rmode = 1'b0;
        wait_idle();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
